// File: rtl/eka_pkg.sv
// eka_pkg: shared decode constants for the decode stage.
// Holds the RV32 base/M opcode values, the ALU operation encodings and
// the immediate-format enum consumed by imm_gen.
package eka_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    // FMT_R means "no immediate": the generator outputs zero
    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_J,
        FMT_U
    } imm_fmt_t;

endpackage

// File: rtl/imm_gen.sv
// imm_gen: combinational RISC-V immediate extraction, sign-extended to XLEN.
// Ports: inst  - 32-bit instruction word
//        fmt   - immediate format selected by the decoder
//        imm   - sign-extended immediate (zero for FMT_R)
module imm_gen
    import eka_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    input  imm_fmt_t        fmt,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;
    // opcode bits carry no immediate information
    logic unused_opc;

    assign unused_opc = ^inst[6:0];

    always_comb begin
        imm32 = '0;
        case (fmt)
            FMT_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
            FMT_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            FMT_U:   imm32 = {inst[31:12], 12'b0};
            default: imm32 = '0;
        endcase
        // a signed source widened by a size cast sign-extends for XLEN = 64
        imm = XLEN'($signed(imm32));
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: single-register RISC-V decode pipeline stage with valid/ready handshakes.
// Ports: clk, reset_n (sync, active-low), flush
//        in_valid/in_ready, in_inst, in_pc        - upstream instruction stream
//        out_valid/out_ready                      - downstream handshake
//        out_pc ... illegal                       - registered decode fields
//        illegal_count                            - saturating count of issued illegal instructions
module decode_stage
    import eka_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int EN_M_EXT = 0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic             write_en,
    output logic [4:0]       write_addr,
    output logic [4:0]       read_addr1,
    output logic [4:0]       read_addr2,
    output logic [XLEN-1:0]  immediate,
    output logic             mem_write_en,
    output logic             mem_read_en,
    output logic [2:0]       funct3,
    output logic [6:0]       funct7,
    output logic [3:0]       alu_opcode,
    output logic             alu_src_imm,
    output logic             branch,
    output logic             jump,
    output logic             is_m_ext,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_count
);

    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [6:0]      shamt_hi;
    logic            shift_bad;
    imm_fmt_t        d_fmt;
    logic [XLEN-1:0] d_imm;
    logic            d_we, d_mw, d_mr, d_br, d_jp, d_mext, d_ill, d_src;
    logic [3:0]      d_alu;
    logic [4:0]      d_ra1;

    assign opc = in_inst[6:0];
    assign f3  = in_inst[14:12];
    assign f7  = in_inst[31:25];
    // on RV64 inst[25] is shamt[5], so only inst[31:26] carry the shift kind
    assign shamt_hi  = (XLEN == 64) ? {in_inst[31:26], 1'b0} : f7;
    assign shift_bad = (f3 == 3'b001) ? (shamt_hi != 7'h00) :
                       (f3 == 3'b101) ? !(shamt_hi == 7'h00 || shamt_hi == 7'h20) : 1'b0;

    assign in_ready = (!out_valid || out_ready) && !flush;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .inst (in_inst),
        .fmt  (d_fmt),
        .imm  (d_imm)
    );

    always_comb begin
        d_fmt  = FMT_R;
        d_we   = 1'b0;
        d_mw   = 1'b0;
        d_mr   = 1'b0;
        d_br   = 1'b0;
        d_jp   = 1'b0;
        d_mext = 1'b0;
        d_ill  = (in_inst[1:0] != 2'b11);
        d_alu  = ALU_ADD;
        d_ra1  = in_inst[19:15];
        d_src  = !(opc == OPC_OP || opc == OPC_BRANCH);
        case (opc)
            OPC_OP_IMM: begin
                d_fmt = FMT_I;
                d_we  = 1'b1;
                d_alu = (f3 == 3'b101) ? {in_inst[30], f3} : {1'b0, f3};
                d_ill = d_ill || shift_bad;
            end
            OPC_OP: begin
                d_we   = 1'b1;
                d_alu  = {in_inst[30], f3};
                d_mext = (f7 == 7'h01) && (EN_M_EXT != 0);
                d_ill  = d_ill || ((f7 == 7'h00) ? 1'b0 :
                                   (f7 == 7'h20) ? !(f3 == 3'b000 || f3 == 3'b101) :
                                   (f7 == 7'h01) ? (EN_M_EXT == 0) : 1'b1);
            end
            OPC_LOAD: begin
                d_fmt = FMT_I;
                d_we  = 1'b1;
                d_mr  = 1'b1;
            end
            OPC_STORE: begin
                d_fmt = FMT_S;
                d_mw  = 1'b1;
            end
            OPC_BRANCH: begin
                d_fmt = FMT_B;
                d_br  = 1'b1;
                d_alu = ALU_SUB;
            end
            OPC_JAL: begin
                d_fmt = FMT_J;
                d_we  = 1'b1;
                d_jp  = 1'b1;
            end
            OPC_JALR: begin
                d_fmt = FMT_I;
                d_we  = 1'b1;
                d_jp  = 1'b1;
            end
            OPC_LUI: begin
                d_fmt = FMT_U;
                d_we  = 1'b1;
                d_ra1 = 5'd0;
            end
            OPC_AUIPC: begin
                d_fmt = FMT_U;
                d_we  = 1'b1;
            end
            default: d_ill = 1'b1;
        endcase
        // an illegal instruction must not cause any architectural side effect
        d_we   = d_we && (in_inst[11:7] != 5'd0) && !d_ill;
        d_mw   = d_mw && !d_ill;
        d_mr   = d_mr && !d_ill;
        d_br   = d_br && !d_ill;
        d_jp   = d_jp && !d_ill;
        d_mext = d_mext && !d_ill;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid     <= 1'b0;
            out_pc        <= '0;
            write_en      <= 1'b0;
            write_addr    <= '0;
            read_addr1    <= '0;
            read_addr2    <= '0;
            immediate     <= '0;
            mem_write_en  <= 1'b0;
            mem_read_en   <= 1'b0;
            funct3        <= '0;
            funct7        <= '0;
            alu_opcode    <= '0;
            alu_src_imm   <= 1'b0;
            branch        <= 1'b0;
            jump          <= 1'b0;
            is_m_ext      <= 1'b0;
            illegal       <= 1'b0;
            illegal_count <= '0;
        end else begin
            // the instruction leaving now is counted even if a flush drops the register
            if (out_valid && out_ready && illegal && !(&illegal_count))
                illegal_count <= illegal_count + CNT_W'(1);
            if (flush) begin
                out_valid <= 1'b0;
            end else if (in_valid && in_ready) begin
                out_valid    <= 1'b1;
                out_pc       <= in_pc;
                write_en     <= d_we;
                write_addr   <= in_inst[11:7];
                read_addr1   <= d_ra1;
                read_addr2   <= in_inst[24:20];
                immediate    <= d_imm;
                mem_write_en <= d_mw;
                mem_read_en  <= d_mr;
                funct3       <= f3;
                funct7       <= f7;
                alu_opcode   <= d_alu;
                alu_src_imm  <= d_src;
                branch       <= d_br;
                jump         <= d_jp;
                is_m_ext     <= d_mext;
                illegal      <= d_ill;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage with a behavioural decode model.
// Ports: none (top-level bench).
module tb_decode_stage;

    localparam int CNT_W = 3;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic        we;
        logic [4:0]  wa;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic        mw;
        logic        mr;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [3:0]  alu;
        logic        src;
        logic        br;
        logic        jp;
        logic        mext;
        logic        ill;
    } exp_t;

    logic clk = 0, reset_n = 0, flush = 0, in_valid = 0, out_ready = 0;
    logic [31:0] in_inst = 0, in_pc = 0;
    logic in_ready, out_valid, write_en, mem_write_en, mem_read_en;
    logic alu_src_imm, branch, jump, is_m_ext, illegal;
    logic [31:0] out_pc, immediate;
    logic [4:0] write_addr, read_addr1, read_addr2;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [3:0] alu_opcode;
    logic [CNT_W-1:0] illegal_count;

    exp_t q[$];
    int checks = 0, failures = 0;
    int occ = 0;
    logic [CNT_W-1:0] cnt_m = 0;
    logic post_reset = 0;

    decode_stage #(.XLEN(32), .EN_M_EXT(0), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .write_en(write_en), .write_addr(write_addr), .read_addr1(read_addr1),
        .read_addr2(read_addr2), .immediate(immediate), .mem_write_en(mem_write_en),
        .mem_read_en(mem_read_en), .funct3(funct3), .funct7(funct7),
        .alu_opcode(alu_opcode), .alu_src_imm(alu_src_imm), .branch(branch),
        .jump(jump), .is_m_ext(is_m_ext), .illegal(illegal), .illegal_count(illegal_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Decode straight from the ISA tables: field meanings, not the RTL's structure.
    function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc);
        exp_t e;
        logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
        logic [2:0] f3;
        logic [6:0] f7;
        imm_i = $unsigned($signed(i) >>> 20);
        imm_s = {{20{i[31]}}, i[31:25], i[11:7]};
        imm_b = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        imm_j = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        imm_u = i & 32'hFFFF_F000;
        f3 = i[14:12];
        f7 = i[31:25];
        e = '0;
        e.pc = pc;
        e.wa = i[11:7];
        e.ra1 = i[19:15];
        e.ra2 = i[24:20];
        e.f3 = f3;
        e.f7 = f7;
        e.src = 1;
        case (i[6:0])
            7'h13: begin
                e.imm = imm_i; e.we = 1;
                e.alu = (f3 == 5) ? {i[30], f3} : {1'b0, f3};
                if (f3 == 1) e.ill = (f7 != 0);
                if (f3 == 5) e.ill = !(f7 == 0 || f7 == 7'h20);
            end
            7'h33: begin
                e.we = 1; e.src = 0; e.alu = {i[30], f3};
                if (f7 == 7'h20) e.ill = !(f3 == 0 || f3 == 5);
                else e.ill = (f7 != 0);
            end
            7'h03: begin e.imm = imm_i; e.we = 1; e.mr = 1; end
            7'h23: begin e.imm = imm_s; e.mw = 1; end
            7'h63: begin e.imm = imm_b; e.br = 1; e.alu = 4'd8; e.src = 0; end
            7'h6F: begin e.imm = imm_j; e.we = 1; e.jp = 1; end
            7'h67: begin e.imm = imm_i; e.we = 1; e.jp = 1; end
            7'h37: begin e.imm = imm_u; e.we = 1; e.ra1 = 0; end
            7'h17: begin e.imm = imm_u; e.we = 1; end
            default: e.ill = 1;
        endcase
        if (e.wa == 0) e.we = 0;
        if (e.ill) begin e.we = 0; e.mw = 0; e.mr = 0; e.br = 0; e.jp = 0; end
        return e;
    endfunction

    // Monitor: samples 1 time unit after the falling edge, well away from posedge.
    initial forever begin
        exp_t e;
        @(negedge clk);
        #1;
        if (post_reset) begin
            chk("reset_zero", {out_valid, write_en, mem_write_en, mem_read_en, branch, jump,
                               illegal, is_m_ext, alu_src_imm, write_addr, read_addr1, read_addr2,
                               funct3, funct7, alu_opcode}, 0);
            chk("reset_imm_pc", {immediate, out_pc}, 0);
            chk("reset_count", illegal_count, 0);
        end
        post_reset = !reset_n;
        chk("out_valid", out_valid, q.size() > 0);
        chk("illegal_count", illegal_count, cnt_m);
        occ = q.size();
        if (!reset_n) begin
            q.delete();
            cnt_m = 0;
        end else if (out_valid && q.size() > 0) begin
            e = q[0];
            chk("out_pc", out_pc, e.pc);
            chk("immediate", immediate, e.imm);
            chk("regs", {write_en, write_addr, read_addr1, read_addr2}, {e.we, e.wa, e.ra1, e.ra2});
            chk("mem", {mem_write_en, mem_read_en}, {e.mw, e.mr});
            chk("funct", {funct3, funct7}, {e.f3, e.f7});
            chk("alu", {alu_opcode, alu_src_imm}, {e.alu, e.src});
            chk("ctrl", {branch, jump, is_m_ext, illegal}, {e.br, e.jp, e.mext, e.ill});
            if (out_ready) begin
                if (e.ill && cnt_m != '1) cnt_m++;
                void'(q.pop_front());
            end else if (flush) begin
                void'(q.pop_front());
            end
        end
    end

    // One stimulus cycle: drive at the falling edge, then predict in_ready and the accept.
    task automatic cyc(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic ordy, input logic fl, input logic rn);
        logic rdy;
        @(negedge clk);
        in_valid = v;
        in_inst = inst;
        in_pc = pc;
        out_ready = ordy;
        flush = fl;
        reset_n = rn;
        #2;
        rdy = (occ == 0 || ordy) && !fl;
        chk("in_ready", in_ready, rdy);
        if (rn && v && rdy) q.push_back(model(inst, pc));
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0] opcs[9];
        logic [6:0] f7s[4];
        logic [31:0] r;
        opcs = '{7'h13, 7'h33, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
        f7s = '{7'h00, 7'h20, 7'h01, 7'h00};
        r = $urandom;
        if ($urandom_range(0, 9) == 0) return r;
        r[6:0] = opcs[$urandom_range(0, 8)];
        if ((r[6:0] == 7'h33 || r[6:0] == 7'h13) && $urandom_range(0, 3) != 0)
            r[31:25] = f7s[$urandom_range(0, 3)];
        return r;
    endfunction

    initial begin
        repeat (3) cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 1);
        // ADDI x1,x0,5
        cyc(1, 32'h00500093, 32'h100, 1, 0, 1);
        cyc(0, 0, 0, 1, 0, 1);
        chk("addi", {out_valid, write_en, write_addr, immediate, alu_opcode, alu_src_imm},
            {1'b1, 1'b1, 5'd1, 32'd5, 4'b0000, 1'b1});
        // SRAI x2,x1,3
        cyc(1, 32'h4030D113, 32'h104, 1, 0, 1);
        cyc(0, 0, 0, 1, 0, 1);
        chk("srai", {alu_opcode, immediate, write_addr}, {4'b1101, 32'h403, 5'd2});
        // SW x2,8(x1)
        cyc(1, 32'h0020A423, 32'h108, 1, 0, 1);
        cyc(0, 0, 0, 1, 0, 1);
        chk("sw", {mem_write_en, write_en, immediate, read_addr2}, {1'b1, 1'b0, 32'd8, 5'd2});
        // backpressure with in_valid held
        cyc(1, 32'h00500093, 32'h200, 1, 0, 1);
        repeat (3) cyc(1, 32'h4030D113, 32'h204, 0, 0, 1);
        chk("bp_hold_pc", out_pc, 32'h200);
        cyc(1, 32'h4030D113, 32'h204, 1, 0, 1);
        cyc(0, 0, 0, 1, 0, 1);
        chk("bp_next_pc", out_pc, 32'h204);
        // illegal pair and the counter
        cyc(0, 0, 0, 1, 0, 1);
        chk("ill_cnt0", illegal_count, 0);
        cyc(1, 32'hFFFFFFFF, 32'h300, 1, 0, 1);
        cyc(1, 32'h02208033, 32'h304, 1, 0, 1);
        chk("ill_ffff", {illegal, write_en}, {1'b1, 1'b0});
        cyc(0, 0, 0, 1, 0, 1);
        chk("ill_mul", {illegal, write_en, illegal_count}, {1'b1, 1'b0, 3'd1});
        cyc(0, 0, 0, 1, 0, 1);
        chk("ill_cnt2", illegal_count, 2);
        // flush while stalled
        cyc(1, 32'h00500093, 32'h400, 1, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(1, 32'h00500093, 32'h404, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("flush_valid", out_valid, 0);
        // reset while stalled on an illegal instruction
        cyc(1, 32'hFFFFFFFF, 32'h500, 1, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(1, 32'h00500093, 32'h504, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("rst_stall", {out_valid, illegal, illegal_count}, 0);
        // randomized traffic; counter width is small so saturation is exercised
        for (int n = 0; n < 4000; n++)
            cyc($urandom_range(0, 3) != 0, rand_inst(), $urandom,
                $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                $urandom_range(0, 399) != 0);
        repeat (3) cyc(0, 0, 0, 1, 0, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width of pc and immediate; legal values are 32 and 64.
REQ-002 Parameter EN_M_EXT, default 0; 1 enables decode of the RV32M (MUL/DIV) group.
REQ-003 Parameter CNT_W, default 16, width of the illegal-instruction counter.
REQ-004 clk  input  1  rising-edge clock; the only clock.
REQ-005 reset_n  input  1  reset; synchronous and active-low.
REQ-006 flush  input  1  discards the held instruction and any instruction accepted in the same cycle.
REQ-007 in_valid / in_ready  input / output  1 / 1  upstream handshake.
REQ-008 in_inst / in_pc  input / input  32 / XLEN  instruction word and its pc.
REQ-009 out_valid / out_ready  output / input  1 / 1  downstream handshake.
REQ-010 Registered outputs:
- out_pc  XLEN
- write_en  1
- write_addr  5
- read_addr1  5
- read_addr2  5
- immediate  XLEN
- mem_write_en  1
- mem_read_en  1
- funct3  3
- funct7  7
- alu_opcode  4
- alu_src_imm  1
- branch  1
- jump  1
- is_m_ext  1
- illegal  1
REQ-011 illegal_count  output  CNT_W  saturating count of illegal instructions issued.

Function
REQ-012 Single pipeline register; an instruction is accepted when in_valid && in_ready, and its decode appears on the outputs at the next edge, giving 1-cycle latency.
REQ-013 in_ready SHALL equal (!out_valid || out_ready) && !flush.
REQ-014 While out_valid && !out_ready, all outputs SHALL hold stable.
REQ-015 Opcodes decoded are OP-IMM, OP, LOAD, STORE, BRANCH, JAL, JALR, LUI and AUIPC; the immediate format is I, S, B, J or U respectively, sign-extended to XLEN. R-type SHALL output immediate 0.
REQ-016 alu_opcode SHALL be:
- {inst[30], funct3} for OP, and for OP-IMM with funct3 = 101;
- {0, funct3} for the rest of OP-IMM;
- 4'b0000 (ADD) for LOAD, STORE, JAL, JALR, LUI and AUIPC;
- 4'b1000 (SUB) for BRANCH.
REQ-017 LUI SHALL force read_addr1 = 0. alu_src_imm SHALL be 1 for every opcode except OP and BRANCH.
REQ-018 write_en SHALL be 1 for OP, OP-IMM, LOAD, JAL, JALR, LUI and AUIPC, and forced to 0 when write_addr = 0.
REQ-019 The following are illegal:
- in_inst[1:0] != 11;
- an undecoded opcode;
- OP with funct7 outside {0000000, 0100000}, or 0100000 with funct3 outside {000, 101};
- OP with funct7 = 0000001 when EN_M_EXT = 0;
- a shift-immediate whose funct7 is invalid.
REQ-020 An illegal instruction issues with illegal = 1 and write_en, mem_*, branch and jump = 0.
REQ-021 illegal_count SHALL increment once per illegal instruction at its output handshake (out_valid && out_ready) and saturate at all-ones.
REQ-022 On flush, out_valid SHALL be 0 at the next edge, and any input handshake in that cycle is suppressed by REQ-013.
REQ-023 Simultaneous output handshake and new accept SHALL replace the register contents with no bubble.

Reset
REQ-024 When reset_n = 0 at an edge, the following SHALL be 0: out_valid, write_en, mem_write_en, mem_read_en, branch, jump, illegal, is_m_ext and illegal_count.
REQ-025 When reset_n = 0 at an edge, all other registered outputs SHALL be 0.
REQ-026 Reset SHALL override flush and handshake, including mid-stall; in_ready = 1 in the first cycle after release.

Structure
REQ-027 Package eka_pkg SHALL hold:
- opcode localparams;
- the ALU opcode encodings;
- the immediate-format enum.
REQ-028 Immediate generation SHALL be a combinational sub-module imm_gen(inst, fmt) -> imm[XLEN-1:0]; everything else stays in decode_stage.

Verification
REQ-029 0x00500093 (ADDI x1,x0,5) accepted -> next cycle: out_valid = 1, write_en = 1, write_addr = 1, immediate = 5, alu_opcode = 0000, alu_src_imm = 1.
REQ-030 0x4030D113 (SRAI x2,x1,3) -> alu_opcode = 1101, immediate = 0x403 sign-extended, write_addr = 2.
REQ-031 0x0020A423 (SW x2,8(x1)) -> mem_write_en = 1, write_en = 0, immediate = 8, read_addr2 = 2.
REQ-032 Backpressure:
- stimulus: out_ready = 0 for 3 cycles with in_valid held;
- response: outputs frozen and in_ready = 0;
- then out_ready = 1 -> the next instruction appears the following cycle, with no drop or duplication.
REQ-033 0xFFFFFFFF and, with EN_M_EXT = 0, 0x02208033 (MUL) -> illegal = 1, write_en = 0, illegal_count goes 0 -> 1 -> 2.
REQ-034 flush with a stalled valid output -> out_valid = 0 next cycle. reset_n = 0 mid-stall -> all outputs 0 and illegal_count = 0.
